press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 1000: cycles a press must be held to count as a long press; legal values are 2 or more.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 300: maximum release-to-second-press gap for a double click; legal values are 2 or more.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the press counter.
REQ-005 clk_i  in  1  system clock; all logic on its rising edge.
REQ-006 rst_i  in  1  synchronous reset, active-high.
REQ-007 db_level_i  in  1  debounced switch level from the upstream debouncer.
REQ-008 db_tick_i  in  1  one-cycle pulse marking a debounced rising edge, from the upstream debouncer.
REQ-009 short_o  out  1  one-cycle pulse: single short press classified.
REQ-010 long_o  out  1  one-cycle pulse: long press classified.
REQ-011 double_o  out  1  one-cycle pulse: double click classified.
REQ-012 press_cnt_o  out  CNT_W  count of accepted presses, saturating.
REQ-013 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, PRESSED, HELD, WAIT_GAP and SECOND, driven by one internal timer.
REQ-015 The timer SHALL be $clog2(max(LONG_CYCLES,GAP_CYCLES)) bits wide, unsigned, cleared on every state entry, and SHALL never wrap.
REQ-016 IDLE: db_tick_i=1 -> PRESSED, timer=0, press counted.
REQ-017 PRESSED: db_level_i=0 -> WAIT_GAP, timer=0; else timer==LONG_CYCLES-1 -> long_o, HELD; else timer++.
REQ-018 PRESSED priority: release SHALL win over long expiry on the same edge.
REQ-019 HELD: db_level_i=0 -> IDLE; no pulse on release.
REQ-020 WAIT_GAP: db_tick_i=1 -> SECOND, timer=0, press counted; else timer==GAP_CYCLES-1 -> short_o, IDLE; else timer++.
REQ-021 WAIT_GAP priority: tick SHALL win over gap expiry on the same edge.
REQ-022 SECOND: db_level_i=0 -> double_o, IDLE; else timer==LONG_CYCLES-1 -> double_o, HELD; else timer++.
REQ-023 A db_tick_i arriving in PRESSED, HELD or SECOND SHALL be ignored and not counted.
REQ-024 Output pulses SHALL be registered and high for exactly the one cycle after the deciding edge.
REQ-025 At most one of short_o, long_o and double_o SHALL be high in any cycle.
REQ-026 Latency: long_o SHALL be high in the cycle after the LONG_CYCLES-th edge following the edge that sampled db_tick_i, provided db_level_i stays high throughout.
REQ-027 press_cnt_o SHALL increment by 1 per counted press and hold at 2^CNT_W-1 (no wrap).
REQ-028 busy_o SHALL be decoded from the registered state, with no added latency.

Reset
REQ-029 rst_i=1 at an edge SHALL force IDLE, timer=0, short_o=long_o=double_o=0, press_cnt_o=0 and busy_o=0.
REQ-030 Reset SHALL take precedence over all inputs.
REQ-031 Reset mid-operation SHALL abort the pending classification with no pulse emitted.
REQ-032 db_tick_i sampled during reset SHALL be dropped.

Verification (LONG_CYCLES=8, GAP_CYCLES=5, CNT_W=4)
REQ-033 Short press: tick, level high 3 cycles, release, idle 10 -> short_o exactly once, 5 edges after release; press_cnt_o=1.
REQ-034 Long press: tick, level high 20 cycles -> long_o exactly 8 edges after tick; no pulse on release; busy_o=0 after release.
REQ-035 Double click: tick, 2 high, release 2, tick, 2 high, release -> double_o once, 0 short_o; press_cnt_o=2.
REQ-036 Boundary cases -> required response:
  - Release at the edge where timer==7 in PRESSED -> no long_o; short_o follows.
  - Second tick at the edge where timer==4 in WAIT_GAP -> SECOND; no short_o.
REQ-037 Saturation: 20 short presses -> press_cnt_o=15.
REQ-038 Reset mid-operation: reset asserted in WAIT_GAP -> no short_o, and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/press_classifier.sv
// press_classifier: turns debounced switch activity into short, long and double-click pulses plus a saturating press count.
module press_classifier #(
    parameter int LONG_CYCLES = 1000,
    parameter int GAP_CYCLES  = 300,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             db_level_i,
    input  logic             db_tick_i,
    output logic             short_o,
    output logic             long_o,
    output logic             double_o,
    output logic [CNT_W-1:0] press_cnt_o,
    output logic             busy_o
);
    localparam int MAX_C = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int TW = $clog2(MAX_C);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PRESSED, HELD, WAIT_GAP, SECOND} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          short_nxt, long_nxt, double_nxt, count;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        count      = 1'b0;
        case (state)
            IDLE: if (db_tick_i) begin
                state_nxt = PRESSED;
                timer_nxt = '0;
                count     = 1'b1;
            end
            // release beats long expiry on the same edge
            PRESSED: if (!db_level_i) begin
                state_nxt = WAIT_GAP;
                timer_nxt = '0;
            end else if (timer == LONG_LAST) begin
                state_nxt = HELD;
                timer_nxt = '0;
                long_nxt  = 1'b1;
            end else begin
                timer_nxt = timer + TW'(1);
            end
            HELD: if (!db_level_i) begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
            // a second press beats gap expiry on the same edge
            WAIT_GAP: if (db_tick_i) begin
                state_nxt = SECOND;
                timer_nxt = '0;
                count     = 1'b1;
            end else if (timer == GAP_LAST) begin
                state_nxt = IDLE;
                timer_nxt = '0;
                short_nxt = 1'b1;
            end else begin
                timer_nxt = timer + TW'(1);
            end
            SECOND: if (!db_level_i) begin
                state_nxt  = IDLE;
                timer_nxt  = '0;
                double_nxt = 1'b1;
            end else if (timer == LONG_LAST) begin
                state_nxt  = HELD;
                timer_nxt  = '0;
                double_nxt = 1'b1;
            end else begin
                timer_nxt = timer + TW'(1);
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            timer       <= '0;
            short_o     <= 1'b0;
            long_o      <= 1'b0;
            double_o    <= 1'b0;
            press_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            short_o  <= short_nxt;
            long_o   <= long_nxt;
            double_o <= double_nxt;
            if (count && !(&press_cnt_o))
                press_cnt_o <= press_cnt_o + CNT_W'(1);
        end
    end

    assign busy_o = (state != IDLE);
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed stimulus with a pulse scoreboard checked by an independent monitor.
module tb_press_classifier;
    logic       clk = 1'b0, rst = 1'b1, db_level = 1'b0, db_tick = 1'b0;
    logic       short_p, long_p, double_p, busy;
    logic [3:0] cnt;
    int         cyc = 0, checks = 0, failures = 0, e, r, kind;

    typedef struct {int kind; int at;} exp_t;
    exp_t sb[$];
    exp_t ex;

    press_classifier #(.LONG_CYCLES(8), .GAP_CYCLES(5), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .db_level_i(db_level), .db_tick_i(db_tick),
        .short_o(short_p), .long_o(long_p), .double_o(double_p),
        .press_cnt_o(cnt), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(output int edge_no);
        db_tick  = 1'b1;
        db_level = 1'b1;
        step();
        edge_no  = cyc;
        db_tick  = 1'b0;
    endtask

    task automatic expect_pulse(input int k, input int at);
        sb.push_back('{kind: k, at: at});
    endtask

    // kind codes: 0 short, 1 long, 2 double
    always @(negedge clk) begin
        if (short_p || long_p || double_p) begin
            kind = long_p ? 1 : (double_p ? 2 : 0);
            check("pulse_onehot", int'(short_p) + int'(long_p) + int'(double_p), 1);
            if (sb.size() == 0) begin
                check("unexpected_pulse_kind", kind, -1);
            end else begin
                ex = sb.pop_front();
                check("pulse_kind", kind, ex.kind);
                check("pulse_edge", cyc, ex.at);
            end
        end
    end

    initial begin
        db_tick  = 1'b1;
        db_level = 1'b1;
        repeat (3) step();
        check("rst_short", int'(short_p), 0);
        check("rst_long", int'(long_p), 0);
        check("rst_double", int'(double_p), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(cnt), 0);
        rst = 1'b0; db_tick = 1'b0; db_level = 1'b0;
        step();
        check("post_rst_cnt", int'(cnt), 0);
        check("post_rst_busy", int'(busy), 0);

        // short press
        press(e);
        check("short_busy_pressed", int'(busy), 1);
        repeat (2) step();
        db_level = 1'b0;
        step();
        expect_pulse(0, cyc + 5);
        check("short_busy_gap", int'(busy), 1);
        repeat (10) step();
        check("short_cnt", int'(cnt), 1);
        check("short_idle", int'(busy), 0);

        // long press with ignored ticks in PRESSED and HELD
        press(e);
        expect_pulse(1, e + 8);
        repeat (3) step();
        db_tick = 1'b1; step(); db_tick = 1'b0;
        repeat (12) step();
        check("long_busy_held", int'(busy), 1);
        db_tick = 1'b1; step(); db_tick = 1'b0;
        repeat (2) step();
        db_level = 1'b0;
        step();
        check("long_idle_after_release", int'(busy), 0);
        check("long_cnt", int'(cnt), 2);

        // double click
        press(e);
        step();
        db_level = 1'b0;
        repeat (2) step();
        press(e);
        step();
        db_level = 1'b0;
        step();
        expect_pulse(2, cyc);
        repeat (8) step();
        check("double_cnt", int'(cnt), 4);
        check("double_idle", int'(busy), 0);

        // release exactly at timer==7 in PRESSED
        press(e);
        repeat (7) step();
        db_level = 1'b0;
        step();
        expect_pulse(0, cyc + 5);
        repeat (8) step();
        check("bound_release_cnt", int'(cnt), 5);

        // second tick exactly at timer==4 in WAIT_GAP
        press(e);
        step();
        db_level = 1'b0;
        step();
        r = cyc;
        repeat (4) step();
        press(e);
        check("bound_tick_edge", e - r, 5);
        check("bound_tick_busy", int'(busy), 1);
        step();
        db_level = 1'b0;
        step();
        expect_pulse(2, cyc);
        repeat (8) step();
        check("bound_tick_cnt", int'(cnt), 7);

        // saturation
        for (int i = 0; i < 20; i++) begin
            press(e);
            db_level = 1'b0;
            step();
            expect_pulse(0, cyc + 5);
            repeat (6) step();
        end
        check("sat_cnt", int'(cnt), 15);

        // reset in WAIT_GAP aborts the short press
        press(e);
        db_level = 1'b0;
        step();
        repeat (2) step();
        rst = 1'b1;
        step();
        check("midrst_short", int'(short_p), 0);
        check("midrst_long", int'(long_p), 0);
        check("midrst_double", int'(double_p), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_cnt", int'(cnt), 0);
        rst = 1'b0;
        repeat (10) step();
        check("midrst_idle_busy", int'(busy), 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
